lsu_stage: RTL

//  Load/store stage directly downstream of the execute stage. Latches one executed

---
 rtl/lsu_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/lsu_stage.sv
// Load/store stage: latches one executed instruction, performs at most one memory
// access over a valid/ready request/response port, and hands the result to write-back.
module lsu_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] rsb_in,
  input  logic              ren_in,
  input  logic              wen_in,
  input  logic [7:0]        wmask_in,
  input  logic [DATA_W-1:0] rmask_in,
  input  logic              mem_signed_in,
  input  logic              reg_write_en_in,
  input  logic [1:0]        wdOp_in,
  input  logic [4:0]        rd_in,
  input  logic [31:0]       pc_in,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result_out,
  output logic              reg_write_en_out,
  output logic [1:0]        wdOp_out,
  output logic [4:0]        rd_out,
  output logic [31:0]       pc_out
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   alu_q, alu_d;
  logic [DATA_W-1:0]   rsb_q, rsb_d;
  logic                ren_q, ren_d;
  logic                wen_q, wen_d;
  logic [7:0]          wmask_q, wmask_d;
  logic [DATA_W-1:0]   rmask_q, rmask_d;
  logic                signed_q, signed_d;
  logic                rwe_q, rwe_d;
  logic [1:0]          wdop_q, wdop_d;
  logic [4:0]          rd_q, rd_d;
  logic [31:0]         pc_q, pc_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic [1:0]          byte_off;
  logic [4:0]          bit_shift;
  logic [DATA_W-1:0]   load_shifted;
  logic [DATA_W-1:0]   load_masked;
  logic                load_sign;
  logic [DATA_W-1:0]   load_data;
  logic [7:0]          strb_wide;

  assign byte_off  = alu_q[1:0];
  assign bit_shift = {byte_off, 3'b000};

  // Sign bit is the top bit of the lane selected by the (contiguous) read mask.
  always_comb begin
    load_shifted = mem_resp_rdata >> bit_shift;
    load_masked  = load_shifted & rmask_q;
    if (rmask_q[31])      load_sign = load_masked[31];
    else if (rmask_q[15]) load_sign = load_masked[15];
    else                  load_sign = load_masked[7];
    load_data = (signed_q && load_sign) ? (load_masked | ~rmask_q) : load_masked;
    strb_wide = wmask_q << byte_off;
  end

  always_comb begin
    state_d  = state_q;
    alu_d    = alu_q;
    rsb_d    = rsb_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    wmask_d  = wmask_q;
    rmask_d  = rmask_q;
    signed_d = signed_q;
    rwe_d    = rwe_q;
    wdop_d   = wdop_q;
    rd_d     = rd_q;
    pc_d     = pc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          alu_d    = alu_result_in;
          rsb_d    = rsb_in;
          ren_d    = ren_in & ~wen_in;
          wen_d    = wen_in;
          wmask_d  = wmask_in;
          rmask_d  = rmask_in;
          signed_d = mem_signed_in;
          rwe_d    = reg_write_en_in;
          wdop_d   = wdOp_in;
          rd_d     = rd_in;
          pc_d     = pc_in;
          result_d = alu_result_in;
          state_d  = (ren_in || wen_in) ? REQ : DONE;
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (mem_resp_valid) begin
          if (ren_q) result_d = load_data;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      alu_q    <= '0;
      rsb_q    <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      wmask_q  <= '0;
      rmask_q  <= '0;
      signed_q <= 1'b0;
      rwe_q    <= 1'b0;
      wdop_q   <= '0;
      rd_q     <= '0;
      pc_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      alu_q    <= alu_d;
      rsb_q    <= rsb_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      wmask_q  <= wmask_d;
      rmask_q  <= rmask_d;
      signed_q <= signed_d;
      rwe_q    <= rwe_d;
      wdop_q   <= wdop_d;
      rd_q     <= rd_d;
      pc_q     <= pc_d;
      result_q <= result_d;
    end
  end

  assign in_ready         = (state_q == IDLE);
  assign mem_req_valid    = (state_q == REQ);
  assign out_valid        = (state_q == DONE);
  assign mem_req_we       = wen_q;
  assign mem_req_addr     = {alu_q[ADDR_W-1:2], 2'b00};
  assign mem_req_wdata    = rsb_q << bit_shift;
  assign mem_req_wstrb    = strb_wide[DATA_W/8-1:0];
  assign result_out       = result_q;
  assign reg_write_en_out = rwe_q;
  assign wdOp_out         = wdop_q;
  assign rd_out           = rd_q;
  assign pc_out           = pc_q;

endmodule
